// File: rtl/fpu_shift_pkg.sv
// Shared types and helpers for the FP significand shifters.
// Holds the default widths, the stage payload layout and the pipeline latency helper.
package fpu_shift_pkg;

    localparam int unsigned SWR_DEF = 26;
    localparam int unsigned EWR_DEF = 5;
    localparam logic [EWR_DEF-1:0] REG_MASK_DEF = 5'b00100;

    // Payload carried through every pipeline register at the default widths.
    typedef struct packed {
        logic [SWR_DEF-1:0] data;
        logic               sticky;
        logic [EWR_DEF-1:0] shift;
        logic               left;
        logic               fill;
    } shift_payload_t;

    // Number of pipeline registers, i.e. latency in cycles, for a register mask.
    function automatic int unsigned pipe_latency(input logic [31:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, mask[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_level_sticky.sv
// One combinational level of the right barrel shifter: shifts by 2^LEVEL when sel is set,
// inserting fill and OR-ing the dropped bits into the running sticky.
module shift_level_sticky
    import fpu_shift_pkg::*;
#(
    parameter int unsigned SWR   = SWR_DEF,
    parameter int unsigned LEVEL = 0
) (
    input  logic [SWR-1:0] data_in,
    input  logic           sel,
    input  logic           fill,
    input  logic           sticky_in,
    output logic [SWR-1:0] data_out,
    output logic           sticky_out
);

    localparam int unsigned AMT = 1 << LEVEL;

    if (AMT >= SWR) begin : g_flush
        // Step at least as wide as the word: everything falls out.
        assign data_out   = sel ? {SWR{fill}} : data_in;
        assign sticky_out = sticky_in | (sel & (|data_in));
    end else begin : g_shift
        assign data_out   = sel ? {{AMT{fill}}, data_in[SWR-1:AMT]} : data_in;
        assign sticky_out = sticky_in | (sel & (|data_in[AMT-1:0]));
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined bidirectional barrel shifter with sticky output and valid/ready flow control.
// REG_MASK bit k places a pipeline register after mux level k; left shifts reuse the right path via bit reversal.
module barrel_shifter_pipe
    import fpu_shift_pkg::*;
#(
    parameter int unsigned     SWR      = SWR_DEF,
    parameter int unsigned     EWR      = EWR_DEF,
    parameter logic [EWR-1:0]  REG_MASK = EWR'(REG_MASK_DEF)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [SWR-1:0] data_i,
    input  logic [EWR-1:0] shift_i,
    input  logic           left_i,
    input  logic           fill_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [SWR-1:0] data_o,
    output logic           sticky_o
);

    typedef struct packed {
        logic [SWR-1:0] data;
        logic           sticky;
        logic [EWR-1:0] shift;
        logic           left;
        logic           fill;
    } payload_t;

    function automatic logic [SWR-1:0] bit_rev(input logic [SWR-1:0] x);
        logic [SWR-1:0] r;
        for (int i = 0; i < SWR; i++) begin
            r[i] = x[SWR-1-i];
        end
        return r;
    endfunction

    payload_t       in_pay;
    payload_t       fin;
    logic [EWR-1:0] stage_vld;
    logic [EWR-1:0] stage_load;
    logic [EWR:0]   rdy;
    logic           unused_tail;

    assign in_pay.data   = left_i ? bit_rev(data_i) : data_i;
    assign in_pay.sticky = 1'b0;
    assign in_pay.shift  = shift_i;
    assign in_pay.left   = left_i;
    assign in_pay.fill   = fill_i;

    // A registered stage loads when empty or when whatever is downstream of it loads.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        rdy      = '0;
        rdy[EWR] = ready_i;
        for (int k = EWR - 1; k >= 0; k--) begin
            rdy[k] = REG_MASK[k] ? (!stage_vld[k] || rdy[k+1]) : rdy[k+1];
        end
    end

    assign stage_load = rdy[EWR-1:0];
    assign ready_o    = rdy[0];

    for (genvar k = 0; k < EWR; k++) begin : g_lvl
        payload_t       pin;
        payload_t       pmux;
        payload_t       pout;
        logic           vin;
        logic           vout;
        logic [SWR-1:0] lvl_data;
        logic           lvl_sticky;

        if (k == 0) begin : g_src
            assign pin = in_pay;
            assign vin = valid_i;
        end else begin : g_link
            assign pin = g_lvl[k-1].pout;
            assign vin = g_lvl[k-1].vout;
        end

        shift_level_sticky #(
            .SWR   (SWR),
            .LEVEL (k)
        ) u_level (
            .data_in    (pin.data),
            .sel        (pin.shift[k]),
            .fill       (pin.fill),
            .sticky_in  (pin.sticky),
            .data_out   (lvl_data),
            .sticky_out (lvl_sticky)
        );

        always_comb begin
            pmux        = pin;
            pmux.data   = lvl_data;
            pmux.sticky = lvl_sticky;
        end

        if (REG_MASK[k]) begin : g_reg
            payload_t pq;
            logic     vq;

            // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vq <= 1'b0;
                    pq <= '0;
                end else if (stage_load[k]) begin
                    vq <= vin;
                    if (vin) begin
                        pq <= pmux;
                    end
                end
            end

            assign pout         = pq;
            assign vout         = vq;
            assign stage_vld[k] = vq;
        end else begin : g_wire
            assign pout         = pmux;
            assign vout         = vin;
            assign stage_vld[k] = 1'b0;
        end
    end

    assign fin      = g_lvl[EWR-1].pout;
    assign valid_o  = g_lvl[EWR-1].vout;
    assign data_o   = fin.left ? bit_rev(fin.data) : fin.data;
    assign sticky_o = fin.sticky;

    // Shift bits and fill are spent by the last level; load enables of unregistered levels go nowhere.
    assign unused_tail = ^{fin.shift, fin.fill, stage_load & ~REG_MASK};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed and scoreboarded checks for barrel_shifter_pipe at L=1 (default), L=5 and L=0.
// DUT 0 carries the directed vectors; all three share stimulus in the random phase.
module tb_barrel_shifter_pipe;
    import fpu_shift_pkg::*;

    typedef struct packed {
        logic [25:0] data;
        logic        sticky;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_i;
    logic [25:0] data_i;
    logic [4:0]  shift_i;
    logic        left_i;
    logic        fill_i;

    logic        ro [3];
    logic        vo [3];
    logic [25:0] dout [3];
    logic        so [3];

    int n_tests;
    int n_fail;
    exp_t q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    barrel_shifter_pipe u_dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ro[0]), .data_i(data_i),
        .shift_i(shift_i), .left_i(left_i), .fill_i(fill_i), .valid_o(vo[0]),
        .ready_i(ready_i), .data_o(dout[0]), .sticky_o(so[0])
    );

    barrel_shifter_pipe #(.REG_MASK(5'b11111)) u_full (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ro[1]), .data_i(data_i),
        .shift_i(shift_i), .left_i(left_i), .fill_i(fill_i), .valid_o(vo[1]),
        .ready_i(ready_i), .data_o(dout[1]), .sticky_o(so[1])
    );

    barrel_shifter_pipe #(.REG_MASK(5'b00000)) u_comb (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ro[2]), .data_i(data_i),
        .shift_i(shift_i), .left_i(left_i), .fill_i(fill_i), .valid_o(vo[2]),
        .ready_i(ready_i), .data_o(dout[2]), .sticky_o(so[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: wide shift with explicit fill mask.
    function automatic exp_t model(input logic [25:0] d, input logic [4:0] s,
                                   input logic l, input logic f);
        exp_t        e;
        logic [63:0] ext;
        logic [25:0] ones;
        logic [25:0] fmask;
        ones = '1;
        if (l) begin
            ext      = {38'b0, d} << s;
            fmask    = ~(ones << s);
            e.data   = ext[25:0] | (f ? fmask : 26'b0);
            e.sticky = |ext[63:26];
        end else begin
            ext      = {d, 38'b0} >> s;
            fmask    = ~(ones >> s);
            e.data   = ext[63:38] | (f ? fmask : 26'b0);
            e.sticky = |ext[37:0];
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [25:0] d, input logic [4:0] s,
                         input logic l, input logic f);
        valid_i = v;
        data_i  = d;
        shift_i = s;
        left_i  = l;
        fill_i  = f;
    endtask

    task automatic one_shot(input string tag, input logic [25:0] d, input logic [4:0] s,
                            input logic l, input logic f, input logic [25:0] ed, input logic es);
        @(negedge clk);
        ready_i = 1'b1;
        drive(1'b1, d, s, l, f);
        @(negedge clk);
        valid_i = 1'b0;
        check({tag, "_valid"}, {31'b0, vo[0]}, 32'd1);
        check({tag, "_data"}, {6'b0, dout[0]}, {6'b0, ed});
        check({tag, "_sticky"}, {31'b0, so[0]}, {31'b0, es});
    endtask

    task automatic scoreboard_step();
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (valid_i && ro[d]) begin
                q[d].push_back(model(data_i, shift_i, left_i, fill_i));
            end
            if (vo[d] && ready_i) begin
                check($sformatf("dut%0d_expected_pending", d), {31'b0, q[d].size() != 0}, 32'd1);
                if (q[d].size() != 0) begin
                    e = q[d].pop_front();
                    check($sformatf("dut%0d_data", d), {6'b0, dout[d]}, {6'b0, e.data});
                    check($sformatf("dut%0d_sticky", d), {31'b0, so[d]}, {31'b0, e.sticky});
                end
            end
        end
    endtask

    initial begin
        int cyc;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        ready_i = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", {31'b0, vo[0]}, 32'd0);
        check("rst_data", {6'b0, dout[0]}, 32'd0);
        check("rst_sticky", {31'b0, so[0]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, ro[0]}, 32'd1);

        // Directed vectors, one cycle latency on the default instance
        one_shot("r4_sticky", 26'h2000001, 5'd4, 1'b0, 1'b0, 26'h0200000, 1'b1);
        one_shot("l1", 26'h0000003, 5'd1, 1'b1, 1'b0, 26'h0000006, 1'b0);
        one_shot("r3_fill1", 26'h0000000, 5'd3, 1'b0, 1'b1, 26'h3800000, 1'b0);
        one_shot("r31_all", 26'h3FFFFFF, 5'd31, 1'b0, 1'b0, 26'h0000000, 1'b1);
        one_shot("shift0", 26'h1555555, 5'd0, 1'b0, 1'b1, 26'h1555555, 1'b0);
        one_shot("l26_fill1", 26'h0000001, 5'd26, 1'b1, 1'b1, 26'h3FFFFFF, 1'b1);
        @(negedge clk);
        check("bubble_after_stream", {31'b0, vo[0]}, 32'd0);

        // Backpressure: A held while B waits, then A, B in order
        ready_i = 1'b0;
        drive(1'b1, 26'h00000F0, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_a_valid", {31'b0, vo[0]}, 32'd1);
        check("bp_a_data", {6'b0, dout[0]}, 32'h0000000F);
        check("bp_full_ready", {31'b0, ro[0]}, 32'd0);
        drive(1'b1, 26'h0000001, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        check("bp_a_held", {6'b0, dout[0]}, 32'h0000000F);
        check("bp_still_full", {31'b0, ro[0]}, 32'd0);
        ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        check("bp_b_valid", {31'b0, vo[0]}, 32'd1);
        check("bp_b_data", {6'b0, dout[0]}, 32'h00000007);
        @(negedge clk);
        check("bp_drained", {31'b0, vo[0]}, 32'd0);

        // Reset mid-stream clears the held output at once
        ready_i = 1'b0;
        drive(1'b1, 26'h0ABCDEF, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        check("mid_valid", {31'b0, vo[0]}, 32'd1);
        check("mid_data", {6'b0, dout[0]}, 32'h0055E6F7);
        check("mid_sticky", {31'b0, so[0]}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, vo[0]}, 32'd0);
        check("async_rst_data", {6'b0, dout[0]}, 32'd0);
        check("async_rst_sticky", {31'b0, so[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("no_stale_valid", {31'b0, vo[0]}, 32'd0);
        check("no_stale_ready", {31'b0, ro[0]}, 32'd1);

        // Latency of the fully registered instance
        ready_i = 1'b1;
        drive(1'b1, 26'h0000010, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        cyc = 1;
        while (!vo[1] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency_l5", cyc, pipe_latency(32'b11111));
        check("latency_l5_data", {6'b0, dout[1]}, 32'd1);
        repeat (8) @(negedge clk);

        // Random streams against the reference model on all three instances
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ready_i = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 3) != 0), 26'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom));
            #1;
            scoreboard_step();
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ready_i = 1'b1;
            valid_i = 1'b0;
            #1;
            scoreboard_step();
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_all_delivered", d), q[d].size(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined bidirectional barrel shifter for the FP adder alignment and normalisation paths.
- Generalises the fixed single-mid-register mux array in three ways:
  - pipeline register placement is set by a parameter;
  - a valid/ready handshake with backpressure is added;
  - a sticky bit (OR of all bits shifted out) is produced for rounding.
- Sits between exponent-difference logic and the significand adder/rounder.

Parameters:
- SWR, 26: significand data width.
- EWR, 5: shift-amount width, one mux level per bit.
- REG_MASK, 5'b00100: EWR bits; bit k=1 puts a pipeline register after mux level k. Latency L = popcount(REG_MASK), range 0..EWR.

Ports:
- clk  in  1  clock; all registers rising-edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  input transaction valid.
- ready_o  out  1  block can accept the input this cycle.
- data_i  in  SWR  operand.
- shift_i  in  EWR  shift amount, unsigned.
- left_i  in  1  1 = shift left, 0 = shift right.
- fill_i  in  1  value written into vacated bit positions.
- valid_o  out  1  output transaction valid.
- ready_i  in  1  downstream accepts the output.
- data_o  out  SWR  shifted result.
- sticky_o  out  1  OR of every bit discarded by the shift.

Behaviour:
- Transfer rules:
  - input accepted when valid_i && ready_o;
  - output consumed when valid_o && ready_i.
- Datapath:
  - left_i=1: reverse bits, right-shift, reverse again. Direction, fill and the partial shift amount travel with the data through every pipeline register.
  - Level k shifts right by 2^k when shift_i[k]=1, inserting fill_i, and ORs the dropped bits into a running sticky.
- Shift >= SWR (e.g. 26..31 with defaults): data_o = all fill_i; sticky_o = OR of all bits of data_i.
- Shift = 0: data_o = data_i, sticky_o = 0.
- Pipeline stages and flow control:
  - Each register stage holds {valid, data, sticky, remaining shift bits, left, fill}.
  - Stage s loads when it is empty or stage s+1 loads (last stage: when ready_i=1). Bubbles therefore collapse.
  - ready_o = first stage load enable.
  - Throughput is 1 transaction/cycle when ready_i=1. Latency is exactly L cycles from acceptance to valid_o.
- L = 0: fully combinational; valid_o=valid_i, ready_o=ready_i, no registers.
- Stall:
  - with ready_i=0, data_o/sticky_o/valid_o stay stable until consumed;
  - no transaction is dropped or duplicated;
  - maximum occupancy is L.
- Reset:
  - rst=0 asynchronously clears all stage valid, data and sticky bits;
  - data_o=0, sticky_o=0, valid_o=0;
  - ready_o=1 on the first cycle after release when L>0.
- Reset mid-operation discards all in-flight transactions; no output is produced for them.
- Simultaneous accept and consume on a full pipeline is legal and keeps it full.
- Inputs are ignored (no state change) when valid_i=0 or ready_o=0.

Decomposition:
- Shared package fpu_shift_pkg:
  - defaults SWR=26 and EWR=5;
  - a function giving L from REG_MASK;
  - a stage-payload struct {data, sticky, shift, left, fill}.
- One sub-module, shift_level_sticky:
  - combinational single mux level with parameters SWR and LEVEL;
  - inputs data, sel, fill, sticky_in; outputs data, sticky_out;
  - instantiated EWR times by generate.
- Pipeline registers are inferred in the top level.

Test Plan (defaults, L=1):
- data_i=26'h2000001, shift 4, right, fill 0 -> one cycle later data_o=26'h0200000, sticky_o=1.
- data_i=26'h0000003, shift 1, left, fill 0 -> data_o=26'h0000006, sticky_o=0.
- data_i=0, shift 3, right, fill 1 -> data_o=26'h3800000, sticky_o=0.
- data_i=26'h3FFFFFF, shift 31, right, fill 0 -> data_o=0, sticky_o=1.
- Backpressure:
  - hold ready_i=0 and stream A, B;
  - A is held on data_o and ready_o=0 while B waits;
  - raise ready_i: A then B are output in order, with no loss or duplication.
- Reset: assert rst=0 mid-stream with valid_o=1 -> valid_o=0 and data_o=0 immediately; no stale output after release. Repeat random 1000-transaction streams with REG_MASK=0, 5'b11111 and 5'b00100 against a reference model.
